// File: rtl/uart_rx_word_assembler.sv
// uart_rx_word_assembler: packs four received bytes into a 32-bit word with an inter-byte timeout (define UART_ASM_BIG_ENDIAN_EN for MSB-first packing)
module uart_rx_word_assembler #(
  parameter int TIMEOUT_CYCLES = 125_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  byte_cnt,
  output logic        timeout_err
);
  localparam int TO_CNT_WIDTH = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;
  state_t state;
  logic accept;
  logic timeout;
  logic [1:0] lane;
  assign in_ready = state != FULL;
  assign accept = in_valid && in_ready && !flush;
`ifdef UART_ASM_BIG_ENDIAN_EN
  assign lane = 2'd3 - byte_cnt;
`else
  assign lane = byte_cnt;
`endif
  if (TIMEOUT_CYCLES > 0) begin : g_to
    logic [TO_CNT_WIDTH-1:0] to_cnt;
    assign timeout = state == COLLECT && !accept && to_cnt == TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    // idle-cycle counter, only runs while a partial word waits for its next byte
    always_ff @(posedge clk or negedge rst)
      if (!rst) to_cnt <= '0;
      else if (flush || accept || timeout || state != COLLECT) to_cnt <= '0;
      else to_cnt <= to_cnt + 1'b1;
  end else begin : g_no_to
    assign timeout = 1'b0;
  end
  // word assembly FSM: flush beats hand-off, hand-off beats accept, accept beats timeout
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      byte_cnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (flush) begin
        state <= IDLE;
        byte_cnt <= '0;
        out_data <= '0;
        out_valid <= 1'b0;
      end else if (state == FULL) begin
        if (out_ready) begin
          state <= IDLE;
          out_data <= '0;
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        out_data[{lane, 3'b000} +: 8] <= in_data;
        byte_cnt <= byte_cnt + 2'd1;
        state <= byte_cnt == 2'd3 ? FULL : COLLECT;
        out_valid <= byte_cnt == 2'd3;
      end else if (timeout) begin
        state <= IDLE;
        byte_cnt <= '0;
        out_data <= '0;
        timeout_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// tb_uart_rx_word_assembler: directed self-checking bench for the word assembler with a 16-cycle timeout
module tb_uart_rx_word_assembler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] out_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [1:0] byte_cnt;
  logic timeout_err;
  int compared = 0;
  int mismatched = 0;
  int pulses;
  logic stuck;

  uart_rx_word_assembler #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .byte_cnt(byte_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [7:0] b0, b1, b2, b3);
`ifdef UART_ASM_BIG_ENDIAN_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_byte_cnt", 32'(byte_cnt), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    rst = 1'b1;
    step();

    send(8'h11);
    chk("le_cnt1", 32'(byte_cnt), 1);
    send(8'h22);
    send(8'h33);
    chk("le_cnt3", 32'(byte_cnt), 3);
    send(8'h44);
    chk("le_valid", 32'(out_valid), 1);
    chk("le_data", out_data, word(8'h11, 8'h22, 8'h33, 8'h44));
    chk("le_in_ready_full", 32'(in_ready), 0);
    chk("le_cnt_wrap", 32'(byte_cnt), 0);
    step();
    chk("le_valid_drop", 32'(out_valid), 0);
    chk("le_data_clr", out_data, 0);

    out_ready = 1'b0;
    send(8'hEF);
    send(8'hBE);
    send(8'hAD);
    send(8'hDE);
    in_valid = 1'b1;
    in_data = 8'h55;
    for (int i = 0; i < 10; i++) begin
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", out_data, word(8'hEF, 8'hBE, 8'hAD, 8'hDE));
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_consumed", 32'(out_valid), 0);
    chk("bp_cnt_after", 32'(byte_cnt), 0);
    step();
    in_valid = 1'b0;
    chk("bp_55_cnt", 32'(byte_cnt), 1);
    chk("bp_55_data", out_data, word(8'h55, 0, 0, 0));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush1_cnt", 32'(byte_cnt), 0);
    chk("flush1_data", out_data, 0);

    send(8'hAA);
    send(8'hBB);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      pulses += int'(timeout_err);
    end
    chk("to_early_pulse", 32'(pulses), 0);
    step();
    chk("to_pulse", 32'(timeout_err), 1);
    chk("to_cnt", 32'(byte_cnt), 0);
    chk("to_data", out_data, 0);
    step();
    chk("to_pulse_once", 32'(timeout_err), 0);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    chk("to_next_valid", 32'(out_valid), 1);
    chk("to_next_data", out_data, word(8'h01, 8'h02, 8'h03, 8'h04));
    step();

    send(8'hA1);
    send(8'hA2);
    for (int i = 0; i < 15; i++) step();
    send(8'hA3);
    chk("bnd_no_pulse", 32'(timeout_err), 0);
    chk("bnd_cnt", 32'(byte_cnt), 3);
    send(8'hA4);
    chk("bnd_valid", 32'(out_valid), 1);
    chk("bnd_data", out_data, word(8'hA1, 8'hA2, 8'hA3, 8'hA4));
    step();

    send(8'hC1);
    send(8'hC2);
    send(8'hC3);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h99;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_cnt", 32'(byte_cnt), 0);
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_data", out_data, 0);
    chk("fl_err", 32'(timeout_err), 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      pulses += int'(timeout_err);
    end
    chk("fl_no_later_pulse", 32'(pulses), 0);

    out_ready = 1'b0;
    send(8'hD1);
    send(8'hD2);
    send(8'hD3);
    send(8'hD4);
    chk("flf_valid_pre", 32'(out_valid), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flf_valid", 32'(out_valid), 0);
    chk("flf_data", out_data, 0);
    chk("flf_in_ready", 32'(in_ready), 1);

    send(8'hE1);
    send(8'hE2);
    send(8'hE3);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_cnt", 32'(byte_cnt), 0);
    chk("arst_data", out_data, 0);
    chk("arst_valid", 32'(out_valid), 0);
    step();
    rst = 1'b1;
    send(8'hF1);
    send(8'hF2);
    send(8'hF3);
    stuck = out_valid;
    chk("arst_no_early_valid", 32'(stuck), 0);
    send(8'hF4);
    chk("arst_word", out_data, word(8'hF1, 8'hF2, 8'hF3, 8'hF4));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart_rx_word_assembler.md
Name: uart_rx_word_assembler

Overview:
Downstream stage of the UART receiver. It consumes received bytes over a ready/valid handshake and packs four consecutive bytes into one 32-bit word. The word is presented to the core-side consumer (bootloader / MMIO load path) over a second ready/valid handshake. An inter-byte timeout discards stale partial words so that a truncated transfer cannot misalign later words.

Parameters:
TIMEOUT_CYCLES, 125_000, max idle clocks between bytes of one word before the partial word is discarded (1 ms @ 125 MHz); 0 disables the timeout
TO_CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1) (derived localparam), width of the timeout counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
flush  input  1  synchronous clear of any partial or held word
in_data  input  8  byte from UART receiver
in_valid  input  1  byte available (receiver data_out_valid)
in_ready  output  1  byte accepted this cycle when high with in_valid (drives receiver data_out_ready)
out_data  output  32  assembled word
out_valid  output  1  word available
out_ready  input  1  consumer accepts word
byte_cnt  output  2  bytes collected in the current partial word
timeout_err  output  1  one-cycle pulse when a partial word is discarded by timeout

Behaviour:
- Reset (rst=0, async): state IDLE, byte_cnt=0, out_data=0, out_valid=0, timeout_err=0, timeout counter=0.
- States:
  - IDLE: byte_cnt=0.
  - COLLECT: byte_cnt 1..3.
  - FULL: word held, out_valid=1.
- in_ready = (state != FULL). It is combinational from state and has no dependence on out_ready; there is no bypass path.
- Byte accept = in_valid && in_ready. The k-th accepted byte (k = byte_cnt, 0..3) is written to out_data[8k+7:8k]. byte_cnt increments modulo 4.
- Transitions:
  - IDLE -> COLLECT on accept.
  - COLLECT -> COLLECT on accept while byte_cnt<3.
  - COLLECT -> FULL on the accept with byte_cnt==3. byte_cnt wraps to 0.
  - FULL -> IDLE on out_valid && out_ready. out_data is cleared to 0 on that edge.
- Latency: out_valid rises on the clock edge that accepts byte 4, so it is visible the following cycle.
- Handshake rules:
  - out_data is stable while out_valid=1.
  - out_valid never drops without out_ready.
  - At least one cycle of in_ready=0 per word (the FULL cycle).
- Timeout counter:
  - Cleared on every accept and in IDLE/FULL.
  - Increments each COLLECT cycle with no accept.
  - When the counter == TIMEOUT_CYCLES-1 in COLLECT with no accept: go to IDLE, byte_cnt=0, out_data=0, timeout_err=1 for exactly one cycle.
  - The pulse is visible TIMEOUT_CYCLES cycles after the last accept edge.
- Simultaneous events:
  - Accept and timeout in the same cycle: the accept wins, the counter clears, and no error is raised.
  - flush: priority over all except reset. It forces IDLE, byte_cnt=0, out_data=0, out_valid=0, and suppresses timeout_err and acceptance in that cycle (in_ready is still reported from the current state, but the byte is dropped). A word held in FULL is discarded.
  - Reset mid-operation: all state is lost immediately; no partial output is produced.
- TIMEOUT_CYCLES=0: the counter logic is removed and a partial word persists indefinitely.

Optional Feature:
UART_ASM_BIG_ENDIAN_EN
- Defined: byte k is written to out_data[31-8k:24-8k], so the first byte lands in the MSB.
- Undefined (default): little-endian packing as above, matching RISC-V memory order.
- No other behaviour changes.

Test Plan:
- Little-endian packing: after reset, send 0x11, 0x22, 0x33, 0x44 with out_ready=1 -> out_valid for 1 cycle with out_data=0x44332211, then byte_cnt=0 and out_data=0. With UART_ASM_BIG_ENDIAN_EN defined -> out_data=0x11223344.
- Backpressure: complete a word 0xDEADBEEF with out_ready=0 for 10 cycles while in_valid=1, in_data=0x55 is held -> in_ready=0 throughout, out_data stays 0xDEADBEEF, 0x55 is not captured. Raise out_ready -> word consumed, then 0x55 is accepted next cycle as byte 0.
- Timeout (TIMEOUT_CYCLES=16): send 0xAA, 0xBB, then idle -> timeout_err pulses exactly 16 cycles after the 0xBB accept, byte_cnt=0. Next bytes 1, 2, 3, 4 -> out_data=0x04030201.
- Timeout boundary (TIMEOUT_CYCLES=16): the third byte arrives in the cycle the counter reaches 15 -> no timeout_err. Completing the word yields the correct 3+1 bytes.
- Flush and reset mid-word: after 3 bytes, pulse flush -> byte_cnt=0, no out_valid, no timeout_err. Repeat with rst=0 asserted asynchronously mid-cycle -> outputs go to reset values before the next clock edge.
